// File: rtl/biset_status_arbiter.sv
// biset_status_arbiter: round-robin publisher of client words into a read-clearing BiSet status register
module biset_status_arbiter #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 24,
  parameter int TIMEOUT = 0,
  parameter int CNT_W = 8,
  localparam int TAG_W = $clog2(N_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SRC-1:0]         src_valid_i,
  input  logic [N_SRC*WIDTH-1:0]   src_data_i,
  output logic [N_SRC-1:0]         src_ack_o,
  output logic [N_SRC-1:0]         src_req_o,
  output logic [WIDTH+TAG_W:0]     stat_val_o,
  output logic                     stat_update_o,
  input  logic                     stat_event_i,
  input  logic                     stat_iter_i,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [31:0] TLAST = TIMEOUT == 0 ? '0 : 32'(TIMEOUT - 1);
  state_t state;
  logic [TAG_W-1:0] ptr, g;
  logic [WIDTH-1:0] word;
  logic [31:0] hcnt;
  logic tmo;
  // scanning offsets downward leaves the lowest set offset from ptr as the winner
  always_comb begin
    int idx;
    logic [TAG_W-1:0] c;
    g = '0;
    idx = 0;
    c = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = idx >= N_SRC ? idx - N_SRC : idx;
      c = TAG_W'(idx);
      g = src_valid_i[c] ? c : g;
    end
  end
  assign word = WIDTH'(src_data_i >> (int'(g) * WIDTH));
  assign tmo = TIMEOUT != 0 && hcnt == TLAST;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr <= '0;
      hcnt <= '0;
      src_ack_o <= '0;
      src_req_o <= '0;
      stat_val_o <= '0;
      stat_update_o <= 1'b0;
      busy_o <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      src_ack_o <= '0;
      stat_update_o <= 1'b0;
      src_req_o <= {N_SRC{stat_event_i}};
      if (state == IDLE) begin
        if (|src_valid_i) begin
          src_ack_o <= N_SRC'(1) << g;
          stat_update_o <= 1'b1;
          stat_val_o <= {1'b1, g, word};
          ptr <= g == TAG_W'(N_SRC - 1) ? '0 : g + 1'b1;
          hcnt <= '0;
          state <= HOLD;
          busy_o <= 1'b1;
        end
      end else if (stat_iter_i) begin
        state <= IDLE;
        busy_o <= 1'b0;
      end else if (tmo) begin
        drop_cnt_o <= drop_cnt_o + CNT_W'(drop_cnt_o != '1);
        state <= IDLE;
        busy_o <= 1'b0;
      end else begin
        // a software write clears the register, so republish the held word
        stat_update_o <= stat_event_i;
        hcnt <= hcnt + 1;
      end
    end
  end
endmodule

// File: tb/tb_biset_status_arbiter.sv
// tb_biset_status_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_biset_status_arbiter;
  localparam int N = 4, W = 24, TW = 2, VW = 27, TO = 8, CW = 2;
  logic clk = 0, rst = 0, ev = 0, iter = 0;
  logic [N-1:0] valid = '0, ack, req, pend = '0;
  logic [N*W-1:0] data;
  logic [VW-1:0] val;
  logic upd, busy;
  logic [CW-1:0] drop;
  logic [W-1:0] d [N];
  int errs = 0, checks = 0;
  bit m_hold = 0, m_upd = 0;
  int m_age = 0, m_ptr = 0, m_drop = 0;
  logic [VW-1:0] m_val = '0;
  logic [N-1:0] m_ack = '0, m_req = '0;

  always #5 clk = ~clk;
  always_comb for (int i = 0; i < N; i++) data[i*W +: W] = d[i];

  biset_status_arbiter #(.N_SRC(N), .WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .src_valid_i(valid), .src_data_i(data),
    .src_ack_o(ack), .src_req_o(req), .stat_val_o(val), .stat_update_o(upd),
    .stat_event_i(ev), .stat_iter_i(iter), .busy_o(busy), .drop_cnt_o(drop));

  function automatic int pick(int p, logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model();
    int g;
    if (rst) begin
      m_hold = 0; m_age = 0; m_ptr = 0; m_drop = 0; m_val = '0;
      m_ack = '0; m_req = '0; m_upd = 0;
    end else begin
      m_req = ev ? '1 : '0;
      m_ack = '0;
      m_upd = 0;
      if (!m_hold) begin
        g = pick(m_ptr, valid);
        if (g >= 0) begin
          m_ack[g] = 1'b1;
          m_upd = 1;
          m_val = {1'b1, TW'(g), d[g]};
          m_ptr = (g + 1) % N;
          m_hold = 1;
          m_age = 0;
        end
      end else if (iter) m_hold = 0;
      else if (m_age == TO - 1) begin
        m_hold = 0;
        if (m_drop < (1 << CW) - 1) m_drop++;
      end else begin
        m_upd = ev;
        m_age++;
      end
    end
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    valid = pend;
    @(posedge clk);
    model();
    #1;
    chk("m_ack", 32'(ack), 32'(m_ack));
    chk("m_upd", 32'(upd), 32'(m_upd));
    chk("m_req", 32'(req), 32'(m_req));
    chk("m_busy", 32'(busy), 32'(m_hold));
    chk("m_val", 32'(val), 32'(m_val));
    chk("m_drop", 32'(drop), 32'(m_drop[CW-1:0]));
    pend &= ~ack;
  endtask

  typedef struct {
    logic [3:0] raise;
    logic it, e, r;
    logic [3:0] ack;
    logic upd, busy;
    logic [3:0] req;
    logic [26:0] val;
  } vec_t;
  vec_t tbl [$];

  initial begin
    int t;
    d[0] = 24'h111111; d[1] = 24'h222222; d[2] = 24'hABCDEF; d[3] = 24'h444444;
    tbl.push_back('{4'h0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 27'h0});
    tbl.push_back('{4'h4, 0, 0, 0, 4'h4, 1, 1, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h0, 0, 1, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 0, 1, 0, 4'h0, 1, 1, 4'hF, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h0, 0, 1, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 1, 1, 0, 4'h0, 0, 0, 4'hF, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 0, 0, 1, 4'h0, 0, 0, 4'h0, 27'h0});
    tbl.push_back('{4'hF, 0, 0, 0, 4'h1, 1, 1, 4'h0, 27'h4111111});
    tbl.push_back('{4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h4111111});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h2, 1, 1, 4'h0, 27'h5222222});
    tbl.push_back('{4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h5222222});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h4, 1, 1, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h6ABCDEF});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h8, 1, 1, 4'h0, 27'h7444444});
    tbl.push_back('{4'h1, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h7444444});
    tbl.push_back('{4'h0, 0, 0, 0, 4'h1, 1, 1, 4'h0, 27'h4111111});
    tbl.push_back('{4'h0, 1, 0, 0, 4'h0, 0, 0, 4'h0, 27'h4111111});
    for (int i = 0; i < tbl.size(); i++) begin
      pend |= tbl[i].raise;
      iter = tbl[i].it; ev = tbl[i].e; rst = tbl[i].r;
      step();
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_upd", i), 32'(upd), 32'(tbl[i].upd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_req", i), 32'(req), 32'(tbl[i].req));
      chk($sformatf("v%0d_val", i), 32'(val), 32'(tbl[i].val));
    end
    iter = 0; ev = 0; rst = 0;
    for (int n = 1; n <= 5; n++) begin
      if (pend == '0) pend = '1;
      t = 0;
      do begin step(); t++; end while (!upd && t < 20);
      chk("to_grant", 32'(upd), 32'd1);
      repeat (7) step();
      chk("to_hold", 32'(busy), 32'd1);
      step();
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_drop", 32'(drop), 32'(n < 3 ? n : 3));
    end
    rst = 1; pend = '0; step();
    rst = 0; pend = 4'b0100; step();
    chk("rh_ack", 32'(ack), 32'h4);
    step();
    rst = 1; pend = 4'b1001; step();
    chk("rh_ack0", 32'(ack), 32'h0);
    chk("rh_val0", 32'(val), 32'h0);
    chk("rh_busy0", 32'(busy), 32'h0);
    chk("rh_drop0", 32'(drop), 32'h0);
    rst = 0; step();
    chk("rh_first", 32'(ack), 32'h1);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(3) == 0) begin
          d[i] = W'($urandom);
          pend[i] = 1'b1;
        end
      iter = $urandom_range(99) < (k < 1500 ? 30 : 6);
      ev = $urandom_range(7) == 0;
      rst = $urandom_range(299) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
